// File: rtl/uart_rx.sv
// 8N1 LSB-first UART receiver with two-flop input synchronizer,
// mid-bit sampling, a one-cycle byte strobe and framing-error strobe.
module uart_rx #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_Serial,
    output logic       o_Rx_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Active
);

    localparam logic [15:0] HALF = 16'((CLKS_PER_BIT - 1) / 2);
    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        CLEANUP
    } state_e;

    state_e      state_q, state_d;
    logic        meta_q, rx_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  data_q, data_d;
    logic [7:0]  byte_q, byte_d;
    logic        dv_q, dv_d;
    logic        err_q, err_d;
    logic        active_q, active_d;

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            meta_q   <= 1'b1;
            rx_q     <= 1'b1;
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            data_q   <= '0;
            byte_q   <= '0;
            dv_q     <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            meta_q   <= i_Rx_Serial;
            rx_q     <= meta_q;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            data_q   <= data_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            err_q    <= err_d;
            active_q <= active_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        data_d   = data_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        err_d    = 1'b0;
        active_d = active_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                idx_d = '0;
                if (!rx_q) begin
                    state_d  = START;
                    active_d = 1'b1;
                end
            end
            START: begin
                if (cnt_q != HALF) begin
                    cnt_d = cnt_q + 16'd1;
                end else if (!rx_q) begin
                    cnt_d   = '0;
                    state_d = DATA;
                end else begin
                    // start bit vanished by mid-bit: treat as noise
                    cnt_d    = '0;
                    active_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            DATA: begin
                if (cnt_q != LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d         = '0;
                    data_d[idx_q] = rx_q;
                    if (idx_q == 3'd7) begin
                        idx_d   = '0;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STOP: begin
                if (cnt_q != LAST) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d    = '0;
                    active_d = 1'b0;
                    state_d  = CLEANUP;
                    if (rx_q) begin
                        byte_d = data_q;
                        dv_d   = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CLEANUP: begin
                // a held-low line (break) waits here instead of restarting
                if (rx_q) state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                active_d = 1'b0;
            end
        endcase
    end

    assign o_Rx_DV        = dv_q;
    assign o_Rx_Byte      = byte_q;
    assign o_Rx_Frame_Err = err_q;
    assign o_Rx_Active    = active_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, 8N1, LSB-first, the receive counterpart of the team's `uart_tx`, with the same `CLKS_PER_BIT` baud convention. It sits between the external RX pin and the command/data path. It synchronizes the asynchronous serial line and qualifies start bits by mid-bit sampling. It delivers each byte with a one-cycle valid strobe and flags framing errors, including line-break conditions.

## Interface
- `CLKS_PER_BIT`, 234: clock cycles per bit; legal range 4..65535. Half-bit point `H = (CLKS_PER_BIT-1)/2` (integer division).
- `i_Clock`  in  1  system clock; all logic on the rising edge.
- `i_Reset`  in  1  reset; asynchronous, active-high.
- `i_Rx_Serial`  in  1  asynchronous serial line, idle high.
- `o_Rx_DV`  out  1  one-cycle strobe: `o_Rx_Byte` updated with a good frame.
- `o_Rx_Byte`  out  8  last good byte received; holds between frames.
- `o_Rx_Frame_Err`  out  1  one-cycle strobe: stop bit sampled low.
- `o_Rx_Active`  out  1  high while a frame is being received.

## Operation
- **Synchronizer**
  - Two flops, both reset to 1. `r_Rx` is the second flop's output.
  - All decisions use `r_Rx` only.
- **Internal state**
  - 16-bit bit-time counter `r_Clock_Count`.
  - 3-bit bit index `r_Bit_Index`.
  - 8-bit shift register `r_Rx_Data`.
- **IDLE**
  - Clear count and index.
  - If `r_Rx==0`: go to START and set `o_Rx_Active`.
- **START**
  - If count `!= H`: count++.
  - If count `== H` and `r_Rx==0`: clear count, go to DATA.
  - If count `== H` and `r_Rx==1`: glitch. Clear `o_Rx_Active` and go to IDLE, with no strobe.
- **DATA**
  - If count `!= CLKS_PER_BIT-1`: count++.
  - Otherwise clear count and write `r_Rx_Data[r_Bit_Index] <= r_Rx`.
  - Index 0..6: increment index. Index 7: clear index, go to STOP.
- **STOP**
  - If count `!= CLKS_PER_BIT-1`: count++.
  - Otherwise clear count and `o_Rx_Active`, then go to CLEANUP.
  - If `r_Rx==1`: `o_Rx_Byte <= r_Rx_Data` and pulse `o_Rx_DV`.
  - If `r_Rx==0`: pulse `o_Rx_Frame_Err`. `o_Rx_Byte` is unchanged.
- **CLEANUP**
  - Stay while `r_Rx==0`; go to IDLE when `r_Rx==1`.
  - A break (line held low) therefore yields exactly one error and no spurious restarts.
  - After a good stop, `r_Rx` is already 1, so CLEANUP lasts one cycle.
- **Unused state encodings** → IDLE.
- **Strobe exclusivity:** `o_Rx_DV` and `o_Rx_Frame_Err` are never high together. Each is high for exactly one cycle per frame.
- **Reset**
  - Asynchronously forces state IDLE; count, index and `r_Rx_Data` to 0; synchronizer flops to 1.
  - Outputs: `o_Rx_DV=0`, `o_Rx_Byte=8'h00`, `o_Rx_Frame_Err=0`, `o_Rx_Active=0`.
  - Reset mid-frame abandons the frame silently.
  - If the line is low after reset release, it is treated as a start bit.

## Timing
- **Reference edge k:** the first rising edge at which `i_Rx_Serial` is sampled low.
  - `r_Rx` is low after edge k+1.
  - IDLE→START on edge k+2; `o_Rx_Active` is high from edge k+2.
- **Sampling points**
  - Start-bit validation: edge k+3+H.
  - Data bit i (i = 0..7): edge k+3+H+(i+1)·CLKS_PER_BIT.
  - Stop bit: edge k+3+H+9·CLKS_PER_BIT.
- **Stop-bit edge** updates all of the following together:
  - `o_Rx_DV` or `o_Rx_Frame_Err` rises.
  - `o_Rx_Byte` updates (good frame only).
  - `o_Rx_Active` falls.
- **Strobes** drop on the next edge.
- **Back-to-back frames**
  - The next start bit may begin immediately after one full stop bit.
  - Sampling at mid-stop leaves about half a bit of slack, so a receiver in CLEANUP/IDLE still catches the next falling edge.
- **Tolerance:** about ±4% cumulative baud mismatch over 10 bits at mid-bit sampling.

## Test plan
All scenarios use `CLKS_PER_BIT=16`, so H=7.
1. Send 0xA5 at 16 clocks/bit → one `o_Rx_DV` at edge k+154 with `o_Rx_Byte=0xA5`, `o_Rx_Frame_Err` never high, `o_Rx_Active` high from edge k+2 until k+154.
2. Line low 5 cycles then high, then send 0x3C → no strobe for the glitch, `o_Rx_Active` drops at edge k+10, then one `o_Rx_DV` with `o_Rx_Byte=0x3C`.
3. After a good 0x11, send 0x00 with stop bit low, then line high → one `o_Rx_Frame_Err` pulse, no `o_Rx_DV`, `o_Rx_Byte` stays 0x11.
4. Line low for 30 bit times, then high, then send 0xFF → exactly one `o_Rx_Frame_Err`, no `o_Rx_DV` during the break, then one `o_Rx_DV` with `o_Rx_Byte=0xFF`.
5. Frames 0x00, 0xFF, 0x55 sent back-to-back with no idle gap (e.g. from a `uart_tx` instance with `CLKS_PER_BIT=16`) → three `o_Rx_DV` pulses 160 cycles apart carrying 0x00, 0xFF, 0x55; no errors.
6. Assert `i_Reset` mid data bit 4 of 0xC3 → all outputs at reset values immediately, with no strobe. After release with the line idle, 0x81 is received with `o_Rx_DV`, `o_Rx_Byte=0x81`.
